// File: rtl/rot_tile_buf.sv
// Ping-pong tile buffer that rotates square pixel tiles by 0/90/180/270 degrees.
// Two banks alternate between filling from the write stream and draining rotated through a 2-stage read pipe.
module rot_tile_buf #(
   parameter int PIX_W = 8,
   parameter int TILE  = 4
) (
   input  logic             I_HCLK,
   input  logic             I_RESET,
   input  logic             I_START,
   input  logic             I_DIRECTION,
   input  logic [1:0]       I_DEGREES,
   input  logic [15:0]      I_NUM_TILES,
   input  logic             I_WR_VALID,
   input  logic [PIX_W-1:0] I_WR_DATA,
   output logic             O_WR_READY,
   output logic             O_RD_VALID,
   output logic [PIX_W-1:0] O_RD_DATA,
   input  logic             I_RD_READY,
   output logic             O_BUSY,
   output logic             O_DONE
);

   localparam int NPIX = TILE * TILE;
   localparam int TW   = $clog2(TILE);
   localparam int AW   = 2 * TW;
   localparam logic [AW-1:0] PIX_LAST = AW'(NPIX - 1);

   typedef enum logic {ST_IDLE, ST_RUN} state_t;

   state_t            state_q, state_d;
   logic [1:0]        eff_q, eff_d;
   logic [15:0]       num_q, num_d;
   logic [1:0]        full_q, full_d;
   logic              wr_bank_q, wr_bank_d;
   logic [AW-1:0]     wr_cnt_q, wr_cnt_d;
   logic [15:0]       tiles_wr_q, tiles_wr_d;
   logic              iss_bank_q, iss_bank_d;
   logic [AW-1:0]     iss_cnt_q, iss_cnt_d;
   logic              s1_valid_q, s1_valid_d;
   logic [AW:0]       s1_addr_q, s1_addr_d;
   logic              out_valid_q, out_valid_d;
   logic [PIX_W-1:0]  out_data_q;
   logic              rel_bank_q, rel_bank_d;
   logic [AW-1:0]     rel_cnt_q, rel_cnt_d;
   logic [15:0]       tiles_rd_q, tiles_rd_d;
   logic              done_q, done_d;

   logic [PIX_W-1:0]  bank_mem [2*NPIX];

   logic              wr_ready, wr_fire, wr_last;
   logic              adv, issue, iss_last;
   logic              rd_fire, rel_last;
   logic [TW-1:0]     i_idx, j_idx, src_r, src_c;

   assign wr_ready = (state_q == ST_RUN) && !full_q[wr_bank_q] && (tiles_wr_q < num_q);
   assign wr_fire  = wr_ready && I_WR_VALID;
   assign wr_last  = (wr_cnt_q == PIX_LAST);
   // The read pipe only advances when the output slot is empty or being taken.
   assign adv      = !out_valid_q || I_RD_READY;
   assign issue    = adv && (state_q == ST_RUN) && full_q[iss_bank_q];
   assign iss_last = (iss_cnt_q == PIX_LAST);
   assign rd_fire  = out_valid_q && I_RD_READY;
   assign rel_last = (rel_cnt_q == PIX_LAST);

   // TILE is a power of two, so TILE-1-x is the bitwise complement of x.
   always_comb begin
      i_idx = iss_cnt_q[AW-1:TW];
      j_idx = iss_cnt_q[TW-1:0];
      src_r = i_idx;
      src_c = j_idx;
      case (eff_q)
         2'd1: begin src_r = ~j_idx; src_c = i_idx;  end
         2'd2: begin src_r = ~i_idx; src_c = ~j_idx; end
         2'd3: begin src_r = j_idx;  src_c = ~i_idx; end
         default: ;
      endcase
   end

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_full
         logic set_full, clr_full;
         assign set_full   = wr_fire && wr_last && (wr_bank_q == 1'(gi));
         assign clr_full   = rd_fire && rel_last && (rel_bank_q == 1'(gi));
         assign full_d[gi] = (full_q[gi] | set_full) & ~clr_full;
      end
   endgenerate

   always_comb begin
      state_d     = state_q;
      eff_d       = eff_q;
      num_d       = num_q;
      wr_bank_d   = wr_bank_q;
      wr_cnt_d    = wr_cnt_q;
      tiles_wr_d  = tiles_wr_q;
      iss_bank_d  = iss_bank_q;
      iss_cnt_d   = iss_cnt_q;
      s1_valid_d  = s1_valid_q;
      s1_addr_d   = s1_addr_q;
      out_valid_d = out_valid_q;
      rel_bank_d  = rel_bank_q;
      rel_cnt_d   = rel_cnt_q;
      tiles_rd_d  = tiles_rd_q;
      done_d      = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (I_START) begin
               eff_d      = I_DIRECTION ? (2'd0 - I_DEGREES) : I_DEGREES;
               num_d      = I_NUM_TILES;
               tiles_wr_d = '0;
               tiles_rd_d = '0;
               wr_bank_d  = 1'b0;
               wr_cnt_d   = '0;
               iss_bank_d = 1'b0;
               iss_cnt_d  = '0;
               rel_bank_d = 1'b0;
               rel_cnt_d  = '0;
               if (I_NUM_TILES == 16'd0) done_d = 1'b1;
               else                      state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (rd_fire && rel_last && ((tiles_rd_q + 16'd1) == num_q)) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (wr_fire) begin
         wr_cnt_d = wr_cnt_q + 1'b1;
         if (wr_last) begin
            wr_bank_d  = ~wr_bank_q;
            tiles_wr_d = tiles_wr_q + 16'd1;
         end
      end

      if (adv) begin
         s1_valid_d  = issue;
         out_valid_d = s1_valid_q;
      end
      if (issue) begin
         s1_addr_d = {iss_bank_q, src_r, src_c};
         iss_cnt_d = iss_cnt_q + 1'b1;
         if (iss_last) iss_bank_d = ~iss_bank_q;
      end

      if (rd_fire) begin
         rel_cnt_d = rel_cnt_q + 1'b1;
         if (rel_last) begin
            rel_bank_d = ~rel_bank_q;
            tiles_rd_d = tiles_rd_q + 16'd1;
         end
      end
   end

   always_ff @(posedge I_HCLK) begin
      if (I_RESET) begin
         state_q     <= ST_IDLE;
         eff_q       <= 2'd0;
         num_q       <= '0;
         full_q      <= '0;
         wr_bank_q   <= 1'b0;
         wr_cnt_q    <= '0;
         tiles_wr_q  <= '0;
         iss_bank_q  <= 1'b0;
         iss_cnt_q   <= '0;
         s1_valid_q  <= 1'b0;
         s1_addr_q   <= '0;
         out_valid_q <= 1'b0;
         rel_bank_q  <= 1'b0;
         rel_cnt_q   <= '0;
         tiles_rd_q  <= '0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         eff_q       <= eff_d;
         num_q       <= num_d;
         full_q      <= full_d;
         wr_bank_q   <= wr_bank_d;
         wr_cnt_q    <= wr_cnt_d;
         tiles_wr_q  <= tiles_wr_d;
         iss_bank_q  <= iss_bank_d;
         iss_cnt_q   <= iss_cnt_d;
         s1_valid_q  <= s1_valid_d;
         s1_addr_q   <= s1_addr_d;
         out_valid_q <= out_valid_d;
         rel_bank_q  <= rel_bank_d;
         rel_cnt_q   <= rel_cnt_d;
         tiles_rd_q  <= tiles_rd_d;
         done_q      <= done_d;
      end
   end

   always_ff @(posedge I_HCLK) begin
      if (wr_fire) bank_mem[{wr_bank_q, wr_cnt_q}] <= I_WR_DATA;
   end

   // Registered read doubles as the output holding register during stalls.
   always_ff @(posedge I_HCLK) begin
      if (I_RESET)                out_data_q <= '0;
      else if (adv && s1_valid_q) out_data_q <= bank_mem[s1_addr_q];
   end

   assign O_WR_READY = wr_ready;
   assign O_RD_VALID = out_valid_q;
   assign O_RD_DATA  = out_data_q;
   assign O_BUSY     = (state_q == ST_RUN);
   assign O_DONE     = done_q;

endmodule

// File: tb/tb_rot_tile_buf.sv
// Bench for rot_tile_buf: random handshakes checked against a matrix-rotation reference model.
module tb_rot_tile_buf;
   localparam int PIX_W = 8;
   localparam int TILE  = 4;
   localparam int NP    = TILE * TILE;

   logic             clk = 1'b0;
   logic             rst, start, dir;
   logic [1:0]       deg;
   logic [15:0]      num;
   logic             wr_valid, wr_ready, rd_valid, rd_ready, busy, done;
   logic [PIX_W-1:0] wr_data, rd_data;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   logic [7:0] wbuf [NP];
   logic [7:0] exp_q [$];
   logic [7:0] rx_q [$];

   int   r_xfers, r_dcnt, r_lat, r_done_gap, r_gaps;
   logic r_blk_val;
   bit   r_blk_seen;

   always #5 clk = ~clk;

   rot_tile_buf #(.PIX_W(PIX_W), .TILE(TILE)) dut (
      .I_HCLK(clk), .I_RESET(rst), .I_START(start), .I_DIRECTION(dir),
      .I_DEGREES(deg), .I_NUM_TILES(num), .I_WR_VALID(wr_valid), .I_WR_DATA(wr_data),
      .O_WR_READY(wr_ready), .O_RD_VALID(rd_valid), .O_RD_DATA(rd_data),
      .I_RD_READY(rd_ready), .O_BUSY(busy), .O_DONE(done)
   );

   task automatic tick;
      @(posedge clk);
      #1;
      cyc++;
   endtask

   // Reference: rotate the tile clockwise by 90 degrees eff times, emit row-major.
   task automatic push_tile(input int eff);
      logic [7:0] cur [NP];
      logic [7:0] nxt [NP];
      cur = wbuf;
      for (int r = 0; r < eff; r++) begin
         for (int i = 0; i < TILE; i++)
            for (int j = 0; j < TILE; j++)
               nxt[i*TILE+j] = cur[(TILE-1-j)*TILE+i];
         cur = nxt;
      end
      for (int k = 0; k < NP; k++) exp_q.push_back(cur[k]);
   endtask

   task automatic run_job(input string name, input int n_tiles, input bit d, input logic [1:0] dg,
                          input int wr_pct, input int rd_pct, input int hold_wr,
                          input int abort_after, input bit mid_start, input bit seq_data);
      int eff, writes, xf, dcnt, last_wr, first_v, last_xf, done_cyc;
      bit prev_stall, aborted;
      logic [7:0] prev_data, e;
      eff = d ? (4 - int'(dg)) % 4 : int'(dg);
      exp_q.delete();
      rx_q.delete();
      writes = 0; xf = 0; dcnt = 0; last_wr = -1; first_v = -1; last_xf = -1; done_cyc = -1;
      prev_stall = 0; aborted = 0; prev_data = '0;
      r_gaps = 0; r_blk_seen = 0; r_blk_val = 1'b1;
      start = 1'b1; dir = d; deg = dg; num = 16'(n_tiles);
      tick;
      start = 1'b0;
      total++;
      if (busy !== 1'b1) begin
         bad++; $display("FAIL %s busy_after_start: got %b want 1", name, busy);
      end
      for (int c = 0; c < 4000; c++) begin
         if (prev_stall) begin
            total++;
            if (rd_valid !== 1'b1 || rd_data !== prev_data) begin
               bad++;
               $display("FAIL %s stall_hold: valid=%b data=%0d want valid=1 data=%0d", name, rd_valid, rd_data, prev_data);
            end
         end
         if (done === 1'b1) begin dcnt++; done_cyc = cyc; end
         if (rd_valid === 1'b1 && first_v < 0) first_v = cyc;
         if (dcnt > 0) break;
         start = 1'b0;
         if (mid_start && c == 6) begin
            start = 1'b1; dir = ~d; deg = dg + 2'd1; num = 16'd5;
         end
         if (hold_wr > 0 && writes == hold_wr && !r_blk_seen) begin
            r_blk_seen = 1; r_blk_val = wr_ready;
         end
         wr_valid = (writes < n_tiles * NP) && ($urandom_range(99) < wr_pct);
         wr_data  = seq_data ? 8'(writes) : 8'($urandom);
         rd_ready = (hold_wr > 0 && writes < hold_wr) ? 1'b0 : ($urandom_range(99) < rd_pct);
         if (wr_valid && wr_ready === 1'b1) begin
            wbuf[writes % NP] = wr_data;
            writes++;
            last_wr = cyc;
            if (writes % NP == 0) push_tile(eff);
         end
         if (rd_valid === 1'b1 && rd_ready) begin
            total++;
            if (exp_q.size() == 0) begin
               bad++; $display("FAIL %s extra_pixel: got %0d with nothing expected", name, rd_data);
            end else begin
               e = exp_q.pop_front();
               if (rd_data !== e) begin
                  bad++; $display("FAIL %s pixel%0d: got %0d want %0d", name, xf, rd_data, e);
               end
            end
            if (hold_wr > 0 && xf > 0 && xf < 32 && cyc != last_xf + 1) r_gaps++;
            rx_q.push_back(rd_data);
            last_xf = cyc;
            xf++;
         end
         prev_stall = (rd_valid === 1'b1) && !rd_ready;
         prev_data  = rd_data;
         if (abort_after > 0 && xf == abort_after) begin
            tick;
            rst = 1'b1; wr_valid = 1'b0; rd_ready = 1'b0;
            tick;
            total++;
            if ({wr_ready, rd_valid, rd_data, busy, done} !== '0) begin
               bad++;
               $display("FAIL %s reset_outputs: wr_ready=%b rd_valid=%b rd_data=%0d busy=%b done=%b want all 0",
                        name, wr_ready, rd_valid, rd_data, busy, done);
            end
            rst = 1'b0;
            dcnt = 0;
            repeat (6) begin tick; if (done === 1'b1) dcnt++; end
            total++;
            if (dcnt != 0) begin
               bad++; $display("FAIL %s abandoned_done: got %0d pulses want 0", name, dcnt);
            end
            aborted = 1;
            break;
         end
         tick;
      end
      wr_valid = 1'b0; rd_ready = 1'b0; start = 1'b0;
      if (aborted) return;
      r_xfers = xf; r_dcnt = dcnt;
      r_lat = (first_v >= 0 && last_wr >= 0) ? first_v - last_wr : -1;
      r_done_gap = done_cyc - last_xf;
      total++;
      if (dcnt != 1) begin
         bad++; $display("FAIL %s done_seen: got %0d pulses want 1 (cycle budget)", name, dcnt);
      end
      total++;
      if (xf != n_tiles * NP) begin
         bad++; $display("FAIL %s xfer_count: got %0d want %0d", name, xf, n_tiles * NP);
      end
      total++;
      if (r_done_gap != 1) begin
         bad++; $display("FAIL %s done_timing: got %0d cycles after last read want 1", name, r_done_gap);
      end
      tick;
      total++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         bad++; $display("FAIL %s after_done: done=%b busy=%b want 0 0", name, done, busy);
      end
   endtask

   task automatic check_literal(input string name, input int lit [NP]);
      total++;
      if (rx_q.size() != NP) begin
         bad++; $display("FAIL %s literal_len: got %0d want %0d", name, rx_q.size(), NP);
      end else begin
         for (int k = 0; k < NP; k++) begin
            total++;
            if (rx_q[k] !== 8'(lit[k])) begin
               bad++; $display("FAIL %s literal%0d: got %0d want %0d", name, k, rx_q[k], lit[k]);
            end
         end
      end
   endtask

   task automatic test_reset;
      rst = 1'b1; start = 1'b0; dir = 1'b0; deg = 2'd0; num = 16'd0;
      wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;
      tick; tick;
      total++;
      if (wr_ready !== 1'b0) begin bad++; $display("FAIL reset wr_ready: got %b want 0", wr_ready); end
      total++;
      if (rd_valid !== 1'b0) begin bad++; $display("FAIL reset rd_valid: got %b want 0", rd_valid); end
      total++;
      if (rd_data !== '0) begin bad++; $display("FAIL reset rd_data: got %0d want 0", rd_data); end
      total++;
      if (busy !== 1'b0) begin bad++; $display("FAIL reset busy: got %b want 0", busy); end
      total++;
      if (done !== 1'b0) begin bad++; $display("FAIL reset done: got %b want 0", done); end
      rst = 1'b0;
      tick;
   endtask

   task automatic test_rot90;
      int lit [NP] = '{12, 8, 4, 0, 13, 9, 5, 1, 14, 10, 6, 2, 15, 11, 7, 3};
      run_job("rot90", 1, 1'b0, 2'd1, 100, 100, 0, 0, 1'b0, 1'b1);
      check_literal("rot90", lit);
      total++;
      if (r_lat != 3) begin
         bad++; $display("FAIL rot90 first_valid_latency: got %0d want 3 (sample cycles after write decision)", r_lat);
      end
   endtask

   task automatic test_ccw_and_180;
      int lit3 [NP] = '{3, 7, 11, 15, 2, 6, 10, 14, 1, 5, 9, 13, 0, 4, 8, 12};
      int lit2 [NP];
      for (int k = 0; k < NP; k++) lit2[k] = NP - 1 - k;
      run_job("ccw90", 1, 1'b1, 2'd1, 100, 100, 0, 0, 1'b0, 1'b1);
      check_literal("ccw90", lit3);
      run_job("rot180", 1, 1'b0, 2'd2, 100, 100, 0, 0, 1'b0, 1'b1);
      check_literal("rot180", lit2);
   endtask

   task automatic test_back_to_back;
      run_job("b2b", 3, 1'b0, 2'd0, 100, 100, 32, 0, 1'b0, 1'b1);
      total++;
      if (!r_blk_seen || r_blk_val !== 1'b0) begin
         bad++; $display("FAIL b2b wr_ready_both_full: seen=%0d got %b want 0", r_blk_seen, r_blk_val);
      end
      total++;
      if (r_gaps != 0) begin
         bad++; $display("FAIL b2b gapless_drain: got %0d bubbles want 0", r_gaps);
      end
   endtask

   task automatic test_random;
      run_job("rand270", 5, 1'b0, 2'd3, 60, 50, 0, 0, 1'b0, 1'b0);
      run_job("randccw", 3, 1'b1, 2'd2, 40, 70, 0, 0, 1'b0, 1'b0);
   endtask

   task automatic test_reset_midjob;
      run_job("abort", 2, 1'b0, 2'd1, 100, 100, 0, 10, 1'b0, 1'b0);
      run_job("after_abort", 1, 1'b1, 2'd3, 80, 70, 0, 0, 1'b0, 1'b0);
   endtask

   task automatic test_zero_tiles;
      start = 1'b1; dir = 1'b0; deg = 2'd1; num = 16'd0;
      tick;
      start = 1'b0;
      total++;
      if (done !== 1'b1 || busy !== 1'b0) begin
         bad++; $display("FAIL zero done_pulse: done=%b busy=%b want 1 0", done, busy);
      end
      tick;
      total++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         bad++; $display("FAIL zero after_pulse: done=%b busy=%b want 0 0", done, busy);
      end
   endtask

   task automatic test_start_in_run;
      run_job("start_in_run", 1, 1'b0, 2'd1, 70, 80, 0, 0, 1'b1, 1'b0);
   endtask

   initial begin
      test_reset;
      test_rot90;
      test_ccw_and_180;
      test_back_to_back;
      test_random;
      test_reset_midjob;
      test_zero_tiles;
      test_start_in_run;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/rot_tile_buf.md
ROT_TILE_BUF -- requirements
Module: rot_tile_buf

Interface
REQ-001 Parameter PIX_W, default 8, pixel width in bits (1..32).
REQ-002 Parameter TILE, default 4, tile edge in pixels, a power of two (2..16); each tile holds TILE*TILE pixels.
REQ-003 I_HCLK  in  1  sole clock; all state updates on its rising edge.
REQ-004 I_RESET  in  1  reset, synchronous and active-high.
REQ-005 I_START  in  1  one-cycle pulse: latch mode and tile count, begin a job.
REQ-006 I_DIRECTION  in  1  0 = clockwise, 1 = counter-clockwise.
REQ-007 I_DEGREES  in  2  00 = 0, 01 = 90, 10 = 180, 11 = 270 degrees.
REQ-008 I_NUM_TILES  in  16  number of tiles in the job.
REQ-009 I_WR_VALID  in  1, I_WR_DATA  in  PIX_W, O_WR_READY  out  1: row-major input pixel stream.
REQ-010 O_RD_VALID  out  1, O_RD_DATA  out  PIX_W, I_RD_READY  in  1: rotated output pixel stream.
REQ-011 O_BUSY  out  1  high while the state is RUN.
REQ-012 O_DONE  out  1  one-cycle pulse when the job completes.

Function
REQ-013 States: IDLE and RUN only.
- IDLE -> RUN on I_START.
- RUN -> IDLE on the cycle the last pixel of the last tile is accepted on the read side.
REQ-014 I_START is acted on only in IDLE; in RUN it is ignored and the latched mode and count are unchanged.
REQ-015 Latched on I_START: rotation eff = I_DEGREES when I_DIRECTION=0, (4 - I_DEGREES) mod 4 when I_DIRECTION=1; also I_NUM_TILES.
REQ-016 I_START with I_NUM_TILES=0: no RUN; O_DONE pulses on the next cycle; O_BUSY stays low.
REQ-017 Storage: two banks of TILE*TILE x PIX_W, used ping-pong. Each bank has a full flag.
REQ-018 Write accept: O_WR_READY = RUN AND write-bank not full AND tiles-written < latched count.
- A pixel is accepted when I_WR_VALID and O_WR_READY are both high.
REQ-019 Write addressing: accepted pixel k (0..TILE*TILE-1) is source (r,c) = (k/TILE, k mod TILE).
- On accepting the last pixel of a tile, that bank's full flag sets and writing toggles to the other bank.
REQ-020 Read addressing: output pixel k is (i,j) = (k/TILE, k mod TILE), read from source:
- eff 0 -> (i, j)
- eff 1 -> (TILE-1-j, i)
- eff 2 -> (TILE-1-i, TILE-1-j)
- eff 3 -> (j, TILE-1-i)
REQ-021 Read handshake:
- Transfer occurs when O_RD_VALID and I_RD_READY are both high.
- While O_RD_VALID is high and I_RD_READY is low, O_RD_DATA and O_RD_VALID hold stable.
REQ-022 Latency and throughput:
- First O_RD_VALID of a tile asserts exactly 2 cycles after the edge that accepts the tile's last write, provided the read side is idle.
- With I_RD_READY held high, one pixel transfers per cycle with no bubbles, including across tile boundaries when the next bank is already full.
REQ-023 Bank release: the full flag clears on the edge accepting the bank's last read pixel. The write side may write that bank from the next cycle.
REQ-024 Ping-pong overlap: writing one bank while reading the other is fully concurrent.
REQ-025 Counters: tiles-written and tiles-read are 16 bits; the job ends when tiles-read equals the latched count. O_DONE pulses on the cycle after the final read transfer.
REQ-026 O_RD_VALID never asserts for a bank that is not full; O_WR_READY never asserts when both banks are full.

Reset
REQ-027 While I_RESET is high, at the next edge:
- state = IDLE; both full flags = 0; all counters = 0; mode = eff 0; bank pointers = 0.
- O_WR_READY=0, O_RD_VALID=0, O_RD_DATA=0, O_BUSY=0, O_DONE=0.
REQ-028 Reset mid-job abandons all stored pixels; no O_DONE is produced for the abandoned job. Storage contents need not be cleared.

Verification (TILE=4, PIX_W=8)
REQ-029 START, DIR=0, DEG=01, NUM=1; write 0..15 -> output 12,8,4,0,13,9,5,1,14,10,6,2,15,11,7,3; O_DONE pulses once.
REQ-030 DIR=1, DEG=01 (eff 3); write 0..15 -> output 3,7,11,15,2,6,10,14,1,5,9,13,0,4,8,12. DIR=0, DEG=10 -> output 15 down to 0.
REQ-031 NUM=3, I_RD_READY low until 32 pixels are offered -> O_WR_READY drops after pixel 31 (both banks full). Releasing ready drains 48 pixels in order without gaps, with one pixel/cycle from first valid to O_DONE when ready stays high.
REQ-032 Random I_RD_READY and I_WR_VALID toggling, NUM=5, DEG=11 -> O_RD_DATA stable during stalls; output matches the REQ-020 model; exactly 80 transfers.
REQ-033 I_RESET asserted after 10 reads of a 2-tile job -> all outputs zero next cycle; no O_DONE. A following NUM=1 job is correct.
REQ-034 START with NUM=0 -> O_DONE pulses one cycle later; O_BUSY stays 0. START pulsed during RUN is ignored (mode unchanged).
